byte_striping_n: RTL

- Parametrised successor to the two-lane byte-striping stage.
- Sits on the clk_2f domain between the word source and the per-lane serialisers.
- Distributes valid input words round-robin across a runtime-selectable number of lanes (1..NUM_LANES), one registered output word per lane.
- Adds restart/alignment, safe reconfiguration at stripe boundaries, and a completed-stripe counter.

---
 rtl/byte_striping_n.sv | 70 +++++++
 1 files changed

// File: rtl/byte_striping_n.sv
// Round-robin byte striping across 1..NUM_LANES registered lane outputs.
// Lane count changes only take effect when the pointer returns to lane 0.
module byte_striping_n #(
  parameter int WIDTH     = 32,
  parameter int NUM_LANES = 4,
  parameter int LW        = $clog2(NUM_LANES) + 1,
  parameter int PW        = $clog2(NUM_LANES),
  parameter int CNT_W     = 16
) (
  input  logic                       clk_2f,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [LW-1:0]              active_lanes,
  input  logic                       restart,
  output logic [NUM_LANES*WIDTH-1:0] lane_data,
  output logic [NUM_LANES-1:0]       lane_valid,
  output logic [PW-1:0]              lane_ptr,
  output logic [LW-1:0]              cur_lanes,
  output logic [CNT_W-1:0]           stripe_count
);

  logic [PW-1:0] sel;
  logic [PW-1:0] ptr_next;
  logic [LW-1:0] eff;
  logic          wrap;

  always_comb begin
    sel      = restart ? '0 : lane_ptr;
    eff      = active_lanes;
    wrap     = 1'b0;
    ptr_next = lane_ptr;

    if (active_lanes == '0)
      eff = LW'(1);
    else if (active_lanes > LW'(NUM_LANES))
      eff = LW'(NUM_LANES);

    // Wrap is judged against the lane count in effect before this edge.
    wrap = valid_in && (LW'(sel) == cur_lanes - LW'(1));

    if (valid_in)
      ptr_next = wrap ? '0 : sel + PW'(1);
    else if (restart)
      ptr_next = '0;
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      lane_data    <= '0;
      lane_valid   <= '0;
      lane_ptr     <= '0;
      cur_lanes    <= LW'(NUM_LANES);
      stripe_count <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        lane_valid[k] <= valid_in && (sel == PW'(k));
        if (valid_in && (sel == PW'(k)))
          lane_data[k*WIDTH +: WIDTH] <= data_in;
      end
      lane_ptr <= ptr_next;
      if (wrap)
        stripe_count <= stripe_count + CNT_W'(1);
      // Stripe boundary: safe point to adopt a new lane count.
      if (ptr_next == '0)
        cur_lanes <= eff;
    end
  end

endmodule
